multi_fifo_rv: RTL

//   Multi-element FIFO with asymmetric enqueue/dequeue widths and count-based flow control.

---
 rtl/multi_fifo_rv.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multi_fifo_rv.sv
// multi_fifo_rv: circular-buffer FIFO with multi-element enqueue/dequeue per cycle.
//   The producer offers i_in_valid elements and learns through o_in_accept how many
//   were taken (always a prefix). The consumer sees up to N_OUT head elements and
//   retires any count up to o_out_valid. Flow control works on counts only.
// Ports:
//   i_clk, i_rstn (async active-low), i_flush (synchronous clear)
//   i_in_valid / i_in_data / o_in_accept       : enqueue side, lane 0 oldest
//   o_out_valid / o_out_data / i_out_ready     : dequeue side, lane 0 is head
//   o_fill_level, o_free_slots, o_almost_full  : occupancy status
//   o_proto_err                                : sticky protocol violation flag
module multi_fifo_rv #(
  parameter int DATA_W    = 8,
  parameter int N_IN      = 4,
  parameter int N_OUT     = 2,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - N_IN,
  parameter int IN_BITS   = $clog2(N_IN + 1),
  parameter int OUT_BITS  = $clog2(N_OUT + 1),
  parameter int CAP_BITS  = $clog2(DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_flush,
  input  logic [IN_BITS-1:0]      i_in_valid,
  input  logic [N_IN*DATA_W-1:0]  i_in_data,
  output logic [IN_BITS-1:0]      o_in_accept,
  output logic [OUT_BITS-1:0]     o_out_valid,
  output logic [N_OUT*DATA_W-1:0] o_out_data,
  input  logic [OUT_BITS-1:0]     i_out_ready,
  output logic [CAP_BITS-1:0]     o_fill_level,
  output logic [CAP_BITS-1:0]     o_free_slots,
  output logic                    o_almost_full,
  output logic                    o_proto_err
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so pointer+offset sums never overflow before the wrap subtract.
  localparam int W = CAP_BITS + 1;
  localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

  logic [DATA_W-1:0]   r_buf [DEPTH];
  logic [IDX_W-1:0]    r_head, r_tail;
  logic [CAP_BITS-1:0] r_fill;
  logic                r_err;

  logic [IN_BITS-1:0]  w_in_eff, w_acc;
  logic [OUT_BITS-1:0] w_ovld, w_deq;
  logic                w_in_err, w_out_err;
  logic [W-1:0]        w_free;
  logic [IDX_W-1:0]    w_wr_idx [N_IN];
  logic [IDX_W-1:0]    w_rd_idx [N_OUT];

  // Modulo-DEPTH reduction; inputs are always < 2*DEPTH so one subtract is enough,
  // which keeps non-power-of-2 depths correct.
  function automatic logic [IDX_W-1:0] f_wrap(input logic [W-1:0] s);
    return (s >= DEPTH_W) ? IDX_W'(s - DEPTH_W) : IDX_W'(s);
  endfunction

  assign w_free   = DEPTH_W - W'(r_fill);
  // An over-range in_valid is flagged and treated as N_IN so accept stays a real lane prefix.
  assign w_in_err = i_in_valid > IN_BITS'(N_IN);
  assign w_in_eff = w_in_err ? IN_BITS'(N_IN) : i_in_valid;
  // Accept uses only registered free space: same-cycle retires do not make room.
  assign w_acc    = i_flush ? '0 :
                    ((W'(w_in_eff) > w_free) ? IN_BITS'(w_free) : w_in_eff);
  assign w_ovld   = (W'(r_fill) > W'(N_OUT)) ? OUT_BITS'(N_OUT) : OUT_BITS'(r_fill);
  assign w_out_err = i_out_ready > w_ovld;
  assign w_deq    = w_out_err ? w_ovld : i_out_ready;

  for (genvar g = 0; g < N_IN; g++) begin : g_wr
    assign w_wr_idx[g] = f_wrap(W'(r_head) + W'(g));
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_rd
    assign w_rd_idx[g] = f_wrap(W'(r_tail) + W'(g));
    assign o_out_data[g*DATA_W +: DATA_W] = r_buf[w_rd_idx[g]];
  end

  assign o_in_accept   = w_acc;
  assign o_out_valid   = w_ovld;
  assign o_fill_level  = r_fill;
  assign o_free_slots  = CAP_BITS'(w_free);
  assign o_almost_full = W'(r_fill) >= W'(AF_THRESH);
  assign o_proto_err   = r_err;

  // Storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_IN; i++)
      if (i < int'(w_acc)) r_buf[w_wr_idx[i]] <= i_in_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      // Error flag survives flush; only reset clears it.
      r_err <= r_err | w_in_err | w_out_err;
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
        r_fill <= '0;
      end else begin
        r_head <= f_wrap(W'(r_head) + W'(w_acc));
        r_tail <= f_wrap(W'(r_tail) + W'(w_deq));
        r_fill <= r_fill + CAP_BITS'(w_acc) - CAP_BITS'(w_deq);
      end
    end
  end

`ifndef SYNTHESIS
  logic [W-1:0] w_ptr_diff;
  assign w_ptr_diff = (r_head >= r_tail) ? W'(r_head) - W'(r_tail)
                                         : W'(r_head) + DEPTH_W - W'(r_tail);
  a_fill_max: assert property (@(posedge i_clk) disable iff (!i_rstn) W'(r_fill) <= DEPTH_W);
  a_acc_le:   assert property (@(posedge i_clk) disable iff (!i_rstn) w_acc <= i_in_valid);
  a_deq_le:   assert property (@(posedge i_clk) disable iff (!i_rstn) W'(w_deq) <= W'(r_fill));
  a_ptr_fill: assert property (@(posedge i_clk) disable iff (!i_rstn)
                w_ptr_diff == ((W'(r_fill) == DEPTH_W) ? W'(0) : W'(r_fill)));
`endif
endmodule
